// File: rtl/dmem_responder_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_responder_pkg
// Brief    : Shared types and defaults for the data-memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_responder_pkg;

  // Default geometry and timing of the responder
  localparam int          DEF_WORD_BITS = 12;
  localparam logic [31:0] DEF_BASE_ADDR = 32'h0000_0000;
  localparam int          DEF_LATENCY   = 1;

  // Responder state encoding
  typedef logic [0:0] dmem_responder_state_type;
  localparam dmem_responder_state_type ST_IDLE = 1'b0;
  localparam dmem_responder_state_type ST_BUSY = 1'b1;

  // One buffered request waiting for the responder to become free
  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } dmem_pending_type;

  // Core-side request bundle
  typedef struct packed {
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
  } mem_in_type;

  // Core-side response bundle
  typedef struct packed {
    logic        mem_ready;
    logic [31:0] mem_rdata;
  } mem_out_type;

  // Responder-side response: core response plus error and overflow flags
  typedef struct packed {
    mem_out_type mem;
    logic        mem_error;
    logic        mem_ovf;
  } dmem_resp_out_type;

  // Complete register state of the responder
  typedef struct packed {
    dmem_responder_state_type state;
    logic [3:0]               cnt;
    dmem_pending_type         pend;
    logic                     cur_write;
    logic                     cur_err;
    logic                     ovf;
  } dmem_responder_reg_type;

  // True when a byte offset from the base lands inside a RAM of 2**word_bits
  // words; offsets that wrapped below the base are huge and fail this test.
  function automatic logic addr_in_range(input logic [31:0] off, input int word_bits);
    return (off >> (word_bits + 2)) == 32'h0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_responder_if
// Brief    : Core data-port bus between the decode stage and the responder.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        mem_error;
  logic        mem_ovf;

  modport master (
    output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata, mem_error, mem_ovf
  );

  modport slave (
    input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata, mem_error, mem_ovf
  );
endinterface
`default_nettype wire

// File: rtl/dmem_ram.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_ram
// Brief    : Single-port synchronous RAM, 32-bit words, byte write enables,
//            registered read data that only changes on a read access.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_ram #(
  parameter int WORD_BITS = 12
) (
  input  logic                 clk,
  input  logic                 en_i,
  input  logic [3:0]           we_i,
  input  logic [WORD_BITS-1:0] addr_i,
  input  logic [31:0]          wdata_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [2**WORD_BITS];
  logic [31:0] rdata_q;

  // Byte-lane writes, or latch the addressed word when no lane is enabled
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i == 4'h0) begin
        rdata_q <= mem_q[addr_i];
      end
      for (int i = 0; i < 4; i++) begin
        if (we_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Memory-side responder for the core data port. Serves requests
//            from on-chip RAM with a fixed latency, one-cycle ready pulse,
//            and a single-entry pending slot for requests arriving while busy.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int          WORD_BITS = DEF_WORD_BITS,
  parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
  parameter int          LATENCY   = DEF_LATENCY
) (
  input  logic             clk,
  input  logic             rst,
  dmem_responder_if.slave  mem_io
);

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  dmem_responder_reg_type r_q;
  dmem_responder_reg_type r_d;

  mem_in_type             w_in;
  dmem_resp_out_type      w_out;
  logic                   w_ready;

  logic                   w_ram_en;
  logic [3:0]             w_ram_we;
  logic [WORD_BITS-1:0]   w_ram_addr;
  logic [31:0]            w_ram_wdata;
  logic [31:0]            w_ram_rdata;
  logic [31:0]            w_off;
  logic                   w_unused;

  assign w_in.mem_valid = mem_io.mem_valid;
  assign w_in.mem_instr = mem_io.mem_instr;
  assign w_in.mem_addr  = mem_io.mem_addr;
  assign w_in.mem_wdata = mem_io.mem_wdata;
  assign w_in.mem_wstrb = mem_io.mem_wstrb;

  // Fetch tag and the sub-word / above-range offset bits carry no meaning here
  assign w_unused = ^{w_in.mem_instr, w_off};

  // The response cycle is the BUSY cycle in which the countdown has expired
  assign w_ready = (r_q.state == ST_BUSY) && (r_q.cnt == 4'd0);

  // Next-state logic: accept, countdown, pending-slot capture and successor selection
  always_comb begin : p_comb
    dmem_responder_reg_type v;
    dmem_pending_type       req;
    logic                   acc;
    logic [31:0]            acc_addr;
    logic [31:0]            acc_wdata;
    logic [3:0]             acc_wstrb;
    logic                   in_range;

    v           = r_q;
    w_off       = 32'h0;
    w_ram_en    = 1'b0;
    w_ram_we    = 4'h0;
    w_ram_addr  = '0;
    w_ram_wdata = 32'h0;
    acc         = 1'b0;
    acc_addr    = 32'h0;
    acc_wdata   = 32'h0;
    acc_wstrb   = 4'h0;
    in_range    = 1'b0;

    req.valid = w_in.mem_valid;
    req.addr  = w_in.mem_addr;
    req.wdata = w_in.mem_wdata;
    req.wstrb = w_in.mem_wstrb;

    if (r_q.state == ST_IDLE) begin
      if (w_in.mem_valid) begin
        acc       = 1'b1;
        acc_addr  = req.addr;
        acc_wdata = req.wdata;
        acc_wstrb = req.wstrb;
      end
    end else if (r_q.cnt != 4'd0) begin
      v.cnt = r_q.cnt - 4'd1;
      if (w_in.mem_valid) begin
        if (!r_q.pend.valid) begin
          v.pend = req;
        end else begin
          v.ovf = 1'b1;
        end
      end
    end else begin
      // Response cycle: the buffered request has priority over a new one,
      // and the new one (if any) takes the slot it vacates.
      if (r_q.pend.valid) begin
        acc       = 1'b1;
        acc_addr  = r_q.pend.addr;
        acc_wdata = r_q.pend.wdata;
        acc_wstrb = r_q.pend.wstrb;
        v.pend    = req;
      end else if (w_in.mem_valid) begin
        acc       = 1'b1;
        acc_addr  = req.addr;
        acc_wdata = req.wdata;
        acc_wstrb = req.wstrb;
      end else begin
        v.state = ST_IDLE;
      end
    end

    // Accepting a request performs its RAM access now, even for a buffered
    // write, so later reads always observe earlier writes.
    if (acc) begin
      w_off       = acc_addr - BASE_ADDR;
      in_range    = addr_in_range(w_off, WORD_BITS);
      v.state     = ST_BUSY;
      v.cnt       = CNT_LOAD;
      v.cur_write = |acc_wstrb;
      v.cur_err   = !in_range;
      w_ram_en    = in_range;
      w_ram_we    = in_range ? acc_wstrb : 4'h0;
      w_ram_addr  = w_off[WORD_BITS+1:2];
      w_ram_wdata = acc_wdata;
    end

    // Reset drops in-flight and buffered work but leaves the RAM untouched
    if (!rst) begin
      v        = '0;
      v.state  = ST_IDLE;
      w_ram_en = 1'b0;
      w_ram_we = 4'h0;
    end

    r_d = v;
  end

  // State register
  always_ff @(posedge clk) begin
    r_q <= r_d;
  end

  dmem_ram #(
    .WORD_BITS (WORD_BITS)
  ) u_ram (
    .clk     (clk),
    .en_i    (w_ram_en),
    .we_i    (w_ram_we),
    .addr_i  (w_ram_addr),
    .wdata_i (w_ram_wdata),
    .rdata_o (w_ram_rdata)
  );

  assign w_out.mem.mem_ready = w_ready;
  assign w_out.mem.mem_rdata = (w_ready && !r_q.cur_write && !r_q.cur_err) ? w_ram_rdata : 32'h0;
  assign w_out.mem_error     = w_ready && r_q.cur_err;
  assign w_out.mem_ovf       = r_q.ovf;

  assign mem_io.mem_ready = w_out.mem.mem_ready;
  assign mem_io.mem_rdata = w_out.mem.mem_rdata;
  assign mem_io.mem_error = w_out.mem_error;
  assign mem_io.mem_ovf   = w_out.mem_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_dmem_responder
// Brief    : Directed self-checking bench for dmem_responder. Four instances
//            (latency 1, 3, 4 and a small offset RAM) share one stimulus bus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic        instr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  dmem_responder_if if1 ();
  dmem_responder_if if3 ();
  dmem_responder_if if4 ();
  dmem_responder_if ifr ();

  assign if1.mem_valid = valid;  assign if1.mem_instr = instr;  assign if1.mem_addr = addr;
  assign if1.mem_wdata = wdata;  assign if1.mem_wstrb = wstrb;
  assign if3.mem_valid = valid;  assign if3.mem_instr = instr;  assign if3.mem_addr = addr;
  assign if3.mem_wdata = wdata;  assign if3.mem_wstrb = wstrb;
  assign if4.mem_valid = valid;  assign if4.mem_instr = instr;  assign if4.mem_addr = addr;
  assign if4.mem_wdata = wdata;  assign if4.mem_wstrb = wstrb;
  assign ifr.mem_valid = valid;  assign ifr.mem_instr = instr;  assign ifr.mem_addr = addr;
  assign ifr.mem_wdata = wdata;  assign ifr.mem_wstrb = wstrb;

  dmem_responder #(.LATENCY(1)) u_dut1 (.clk(clk), .rst(rst), .mem_io(if1));
  dmem_responder #(.LATENCY(3)) u_dut3 (.clk(clk), .rst(rst), .mem_io(if3));
  dmem_responder #(.LATENCY(4)) u_dut4 (.clk(clk), .rst(rst), .mem_io(if4));
  dmem_responder #(.WORD_BITS(4), .BASE_ADDR(32'h0000_1000), .LATENCY(1))
    u_dutr (.clk(clk), .rst(rst), .mem_io(ifr));

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s);
    valid = v;
    instr = 1'b0;
    addr  = a;
    wdata = d;
    wstrb = s;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    tick();
    n_checks++;
    if (if1.mem_ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", if1.mem_ready);
    else n_pass++;
    n_checks++;
    if (if1.mem_rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 00000000", if1.mem_rdata);
    else n_pass++;
    n_checks++;
    if (if1.mem_error !== 1'b0) $display("FAIL reset_error: got %b want 0", if1.mem_error);
    else n_pass++;
    n_checks++;
    if (if1.mem_ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", if1.mem_ovf);
    else n_pass++;
    n_checks++;
    if (if3.mem_ovf !== 1'b0) $display("FAIL reset_ovf3: got %b want 0", if3.mem_ovf);
    else n_pass++;
    rst = 1'b1;
  endtask

  task automatic test_read_zero();
    drive(1'b1, 32'h0, 32'h0, 4'h0);
    n_checks++;
    if (if1.mem_ready !== 1'b0) $display("FAIL rd0_ready_early: got %b want 0", if1.mem_ready);
    else n_pass++;
    tick();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    n_checks++;
    if (if1.mem_ready !== 1'b1) $display("FAIL rd0_ready: got %b want 1", if1.mem_ready);
    else n_pass++;
    n_checks++;
    if (if1.mem_rdata !== 32'h0) $display("FAIL rd0_rdata: got %h want 00000000", if1.mem_rdata);
    else n_pass++;
    n_checks++;
    if (if1.mem_error !== 1'b0) $display("FAIL rd0_error: got %b want 0", if1.mem_error);
    else n_pass++;
    tick();
    n_checks++;
    if (if1.mem_ready !== 1'b0) $display("FAIL rd0_single_pulse: got %b want 0", if1.mem_ready);
    else n_pass++;
  endtask

  task automatic test_partial_write();
    int pulses;
    pulses = 0;
    drive(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    tick();
    pulses += int'(if1.mem_ready);
    n_checks++;
    if (if1.mem_rdata !== 32'h0) $display("FAIL pw_write_rdata: got %h want 00000000", if1.mem_rdata);
    else n_pass++;
    drive(1'b1, 32'h10, 32'h0000_00AA, 4'h1);
    tick();
    pulses += int'(if1.mem_ready);
    drive(1'b1, 32'h10, 32'h0, 4'h0);
    tick();
    pulses += int'(if1.mem_ready);
    n_checks++;
    if (if1.mem_rdata !== 32'hDEAD_BEAA) $display("FAIL pw_rdata: got %h want deadbeaa", if1.mem_rdata);
    else n_pass++;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    pulses += int'(if1.mem_ready);
    n_checks++;
    if (pulses != 3) $display("FAIL pw_pulses: got %0d want 3", pulses);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] bb [4];
    bb[0] = 32'h0123_4567;
    bb[1] = 32'h89AB_CDEF;
    bb[2] = 32'h5A5A_A5A5;
    bb[3] = 32'hFEDC_BA98;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), bb[i], 4'hF);
      tick();
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(4 * i), 32'h0, 4'h0);
      tick();
      n_checks++;
      if (if1.mem_ready !== 1'b1) $display("FAIL b2b_ready[%0d]: got %b want 1", i, if1.mem_ready);
      else n_pass++;
      n_checks++;
      if (if1.mem_rdata !== bb[i]) $display("FAIL b2b_rdata[%0d]: got %h want %h", i, if1.mem_rdata, bb[i]);
      else n_pass++;
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    n_checks++;
    if (if1.mem_ovf !== 1'b0) $display("FAIL b2b_ovf: got %b want 0", if1.mem_ovf);
    else n_pass++;
    tick();
    n_checks++;
    if (if1.mem_ready !== 1'b0) $display("FAIL b2b_end_ready: got %b want 0", if1.mem_ready);
    else n_pass++;
  endtask

  task automatic test_lat3_pending();
    logic exp_rdy;
    logic exp_ovf;
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    rst = 1'b1;
    for (int cyc = 0; cyc < 9; cyc++) begin
      case (cyc)
        0:       drive(1'b1, 32'h40, 32'h1234_5678, 4'hF);
        1:       drive(1'b1, 32'h40, 32'h0, 4'h0);
        2:       drive(1'b1, 32'h44, 32'h0, 4'h0);
        default: drive(1'b0, 32'h0, 32'h0, 4'h0);
      endcase
      exp_rdy = (cyc == 3) || (cyc == 6);
      exp_ovf = (cyc >= 3);
      n_checks++;
      if (if3.mem_ready !== exp_rdy) $display("FAIL l3_ready[c%0d]: got %b want %b", cyc, if3.mem_ready, exp_rdy);
      else n_pass++;
      n_checks++;
      if (if3.mem_ovf !== exp_ovf) $display("FAIL l3_ovf[c%0d]: got %b want %b", cyc, if3.mem_ovf, exp_ovf);
      else n_pass++;
      if (cyc == 3) begin
        n_checks++;
        if (if3.mem_rdata !== 32'h0) $display("FAIL l3_wr_rdata: got %h want 00000000", if3.mem_rdata);
        else n_pass++;
      end
      if (cyc == 6) begin
        n_checks++;
        if (if3.mem_rdata !== 32'h1234_5678) $display("FAIL l3_rd_rdata: got %h want 12345678", if3.mem_rdata);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] ra [6];
    logic [31:0] rd [6];
    logic [3:0]  rs [6];
    logic [31:0] ed [6];
    logic        ee [6];
    ra[0] = 32'h1000; rd[0] = 32'h1111_2222; rs[0] = 4'hF; ed[0] = 32'h0;         ee[0] = 1'b0;
    ra[1] = 32'h1000; rd[1] = 32'h0;         rs[1] = 4'h0; ed[1] = 32'h1111_2222; ee[1] = 1'b0;
    ra[2] = 32'h0FFC; rd[2] = 32'h0;         rs[2] = 4'h0; ed[2] = 32'h0;         ee[2] = 1'b1;
    ra[3] = 32'h1040; rd[3] = 32'h0;         rs[3] = 4'h0; ed[3] = 32'h0;         ee[3] = 1'b1;
    ra[4] = 32'h1040; rd[4] = 32'hFFFF_FFFF; rs[4] = 4'hF; ed[4] = 32'h0;         ee[4] = 1'b1;
    ra[5] = 32'h1000; rd[5] = 32'h0;         rs[5] = 4'h0; ed[5] = 32'h1111_2222; ee[5] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, ra[i], rd[i], rs[i]);
      tick();
      n_checks++;
      if (ifr.mem_ready !== 1'b1) $display("FAIL oor_ready[%0d]: got %b want 1", i, ifr.mem_ready);
      else n_pass++;
      n_checks++;
      if (ifr.mem_error !== ee[i]) $display("FAIL oor_error[%0d]: got %b want %b", i, ifr.mem_error, ee[i]);
      else n_pass++;
      n_checks++;
      if (ifr.mem_rdata !== ed[i]) $display("FAIL oor_rdata[%0d]: got %h want %h", i, ifr.mem_rdata, ed[i]);
      else n_pass++;
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
  endtask

  task automatic test_reset_mid();
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    tick();
    rst = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc == 0) drive(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF);
      else          drive(1'b0, 32'h0, 32'h0, 4'h0);
      n_checks++;
      if (if4.mem_ready !== (cyc == 4)) $display("FAIL rm_wr_ready[c%0d]: got %b want %b", cyc, if4.mem_ready, (cyc == 4));
      else n_pass++;
      tick();
    end
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (cyc == 0) drive(1'b1, 32'h20, 32'h0, 4'h0);
      else          drive(1'b0, 32'h0, 32'h0, 4'h0);
      rst = (cyc == 2) ? 1'b0 : 1'b1;
      n_checks++;
      if (if4.mem_ready !== 1'b0) $display("FAIL rm_no_ready[c%0d]: got %b want 0", cyc, if4.mem_ready);
      else n_pass++;
      tick();
    end
    rst = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      if (cyc == 0) drive(1'b1, 32'h20, 32'h0, 4'h0);
      else          drive(1'b0, 32'h0, 32'h0, 4'h0);
      n_checks++;
      if (if4.mem_ready !== (cyc == 4)) $display("FAIL rm_rd_ready[c%0d]: got %b want %b", cyc, if4.mem_ready, (cyc == 4));
      else n_pass++;
      if (cyc == 4) begin
        n_checks++;
        if (if4.mem_rdata !== 32'hCAFE_F00D) $display("FAIL rm_rdata: got %h want cafef00d", if4.mem_rdata);
        else n_pass++;
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    test_reset();
    test_read_zero();
    test_partial_write();
    test_back_to_back();
    test_lat3_pending();
    test_out_of_range();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
